// File: rtl/viterbi_ber_checker.sv
// viterbi_ber_checker
// Aligns the decoder output stream against the encoder input stream by
// searching the decode latency, then accumulates bit and error counts while
// locked. A windowed mismatch monitor drops lock and resumes the search when
// the alignment is lost.
`timescale 1ns/1ps

module viterbi_ber_checker #(
  parameter int MAX_LAT  = 64,
  parameter int SRCH_LEN = 32,
  parameter int SRCH_THR = 2,
  parameter int WIN      = 256,
  parameter int LOSS_THR = 64,
  parameter int LAT_W    = $clog2(MAX_LAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             ref_valid,
  input  logic             ref_bit,
  input  logic             dec_valid,
  input  logic             dec_bit,
  output logic             locked,
  output logic [LAT_W-1:0] latency,
  output logic [31:0]      bit_count,
  output logic [31:0]      err_count,
  output logic             err_pulse,
  output logic             sweep_fail
);

  localparam int SW = $clog2(SRCH_LEN + 1);
  localparam int WW = $clog2(WIN + 1);

  localparam logic [SW-1:0]    SRCH_LEN_C = SW'(SRCH_LEN);
  localparam logic [SW-1:0]    SRCH_THR_C = SW'(SRCH_THR);
  localparam logic [WW-1:0]    WIN_C      = WW'(WIN);
  localparam logic [WW-1:0]    LOSS_THR_C = WW'(LOSS_THR);
  localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(MAX_LAT - 1);
  localparam logic [31:0]      CNT_MAX    = 32'hFFFF_FFFF;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [MAX_LAT-1:0] hist;
  logic [LAT_W-1:0]   latency_n;
  logic [SW-1:0]      scnt, scnt_n, scnt_inc;
  logic [SW-1:0]      smis, smis_n, smis_inc;
  logic [WW-1:0]      wcnt, wcnt_n, wcnt_inc;
  logic [WW-1:0]      wmis, wmis_n, wmis_inc;
  logic [31:0]        bit_count_n, err_count_n;
  logic               err_pulse_n, sweep_fail_n;
  logic               mis;

  // Reference history: the compare below reads hist[latency] before this shift.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the history is a plain shift register, so it is reset along with
    // the control state; there is no RAM here that would make that expensive.
    if (!rst) begin
      hist <= '0;
    end else if (ref_valid) begin
      hist <= {hist[MAX_LAT-2:0], ref_bit};
    end
  end

  assign mis    = dec_valid & (dec_bit != hist[latency]);
  assign locked = (state == LOCKED);

  // Next-state and counter updates for the search / locked machine.
  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    state_n      = state;
    latency_n    = latency;
    scnt_n       = scnt;
    smis_n       = smis;
    wcnt_n       = wcnt;
    wmis_n       = wmis;
    bit_count_n  = bit_count;
    err_count_n  = err_count;
    err_pulse_n  = 1'b0;
    sweep_fail_n = sweep_fail;
    scnt_inc     = scnt + SW'(1);
    smis_inc     = smis + SW'(mis);
    wcnt_inc     = wcnt + WW'(1);
    wmis_inc     = wmis + WW'(mis);

    if (clear) begin
      state_n      = SEARCH;
      latency_n    = '0;
      scnt_n       = '0;
      smis_n       = '0;
      wcnt_n       = '0;
      wmis_n       = '0;
      bit_count_n  = '0;
      err_count_n  = '0;
      sweep_fail_n = 1'b0;
    end else if (dec_valid) begin
      unique case (state)
        SEARCH: begin
          if (scnt_inc == SRCH_LEN_C) begin
            scnt_n = '0;
            smis_n = '0;
            if (smis_inc <= SRCH_THR_C) begin
              state_n = LOCKED;
              wcnt_n  = '0;
              wmis_n  = '0;
            end else begin
              latency_n = latency + LAT_W'(1);
              if (latency == LAT_LAST) sweep_fail_n = 1'b1;
            end
          end else begin
            scnt_n = scnt_inc;
            smis_n = smis_inc;
          end
        end
        LOCKED: begin
          // Statistics freeze together once bit_count has saturated.
          if (bit_count != CNT_MAX) begin
            bit_count_n = bit_count + 32'd1;
            if (mis) begin
              if (err_count != CNT_MAX) err_count_n = err_count + 32'd1;
              err_pulse_n = 1'b1;
            end
          end
          if (wcnt_inc == WIN_C) begin
            wcnt_n = '0;
            wmis_n = '0;
            if (wmis_inc > LOSS_THR_C) begin
              state_n   = SEARCH;
              latency_n = latency + LAT_W'(1);
              scnt_n    = '0;
              smis_n    = '0;
            end
          end else begin
            wcnt_n = wcnt_inc;
            wmis_n = wmis_inc;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  // Register the machine state, counters and strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SEARCH;
      latency    <= '0;
      scnt       <= '0;
      smis       <= '0;
      wcnt       <= '0;
      wmis       <= '0;
      bit_count  <= '0;
      err_count  <= '0;
      err_pulse  <= 1'b0;
      sweep_fail <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state      <= state_n;
      latency    <= latency_n;
      scnt       <= scnt_n;
      smis       <= smis_n;
      wcnt       <= wcnt_n;
      wmis       <= wmis_n;
      bit_count  <= bit_count_n;
      err_count  <= err_count_n;
      err_pulse  <= err_pulse_n;
      sweep_fail <= sweep_fail_n;
    end
  end

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Self-checking bench for viterbi_ber_checker: random traffic against a
// queue-based behavioural model, compared on every falling edge, plus literal
// expectations for the directed scenarios.
`timescale 1ns/1ps

module tb_viterbi_ber_checker;

  localparam int MAX_LAT  = 64;
  localparam int SRCH_LEN = 32;
  localparam int SRCH_THR = 2;
  localparam int WIN      = 256;
  localparam int LOSS_THR = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        ref_valid = 1'b0;
  logic        ref_bit = 1'b0;
  logic        dec_valid = 1'b0;
  logic        dec_bit = 1'b0;
  logic        locked;
  logic [5:0]  latency;
  logic [31:0] bit_count;
  logic [31:0] err_count;
  logic        err_pulse;
  logic        sweep_fail;

  viterbi_ber_checker #(
    .MAX_LAT (MAX_LAT),
    .SRCH_LEN(SRCH_LEN),
    .SRCH_THR(SRCH_THR),
    .WIN     (WIN),
    .LOSS_THR(LOSS_THR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .ref_valid (ref_valid),
    .ref_bit   (ref_bit),
    .dec_valid (dec_valid),
    .dec_bit   (dec_bit),
    .locked    (locked),
    .latency   (latency),
    .bit_count (bit_count),
    .err_count (err_count),
    .err_pulse (err_pulse),
    .sweep_fail(sweep_fail)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mh[k] is the ref bit accepted k+1 ref events ago.
  bit          mh[$];
  bit          m_lk, m_sw, m_pulse;
  int          m_lat, m_scnt, m_smis, m_wcnt, m_wmis;
  logic [31:0] m_bc, m_ec;

  task automatic model_reset();
    mh.delete();
    for (int i = 0; i < MAX_LAT; i++) mh.push_back(1'b0);
    m_lk = 0; m_sw = 0; m_pulse = 0;
    m_lat = 0; m_scnt = 0; m_smis = 0; m_wcnt = 0; m_wmis = 0;
    m_bc = '0; m_ec = '0;
  endtask

  task automatic model_step();
    bit m;
    m = dec_valid && (dec_bit != mh[m_lat]);
    m_pulse = 0;
    if (clear) begin
      m_lk = 0; m_sw = 0; m_lat = 0;
      m_scnt = 0; m_smis = 0; m_wcnt = 0; m_wmis = 0;
      m_bc = '0; m_ec = '0;
    end else if (dec_valid) begin
      if (!m_lk) begin
        m_scnt++;
        m_smis += int'(m);
        if (m_scnt == SRCH_LEN) begin
          if (m_smis <= SRCH_THR) m_lk = 1;
          else begin
            if (m_lat == MAX_LAT - 1) m_sw = 1;
            m_lat = (m_lat + 1) % MAX_LAT;
          end
          m_scnt = 0; m_smis = 0;
        end
      end else begin
        if (m_bc != 32'hFFFF_FFFF) begin
          m_bc = m_bc + 1;
          if (m) begin m_ec = m_ec + 1; m_pulse = 1; end
        end
        m_wcnt++;
        m_wmis += int'(m);
        if (m_wcnt == WIN) begin
          if (m_wmis > LOSS_THR) begin
            m_lk = 0;
            m_lat = (m_lat + 1) % MAX_LAT;
          end
          m_wcnt = 0; m_wmis = 0;
        end
      end
    end
    if (ref_valid) begin
      mh.push_front(ref_bit);
      void'(mh.pop_back());
    end
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // ---------------- compare / monitor ----------------
  int  pulse_cnt   = 0;
  bit  seen_unlock = 0;
  bit  seen_wrap   = 0;
  int  prev_lat    = 0;

  always @(negedge clk) begin
    check("locked",     64'(locked),     64'(m_lk));
    check("latency",    64'(latency),    64'(m_lat));
    check("bit_count",  64'(bit_count),  64'(m_bc));
    check("err_count",  64'(err_count),  64'(m_ec));
    check("err_pulse",  64'(err_pulse),  64'(m_pulse));
    check("sweep_fail", 64'(sweep_fail), 64'(m_sw));
    if (err_pulse === 1'b1) pulse_cnt++;
    if (locked === 1'b0) seen_unlock = 1;
    if (latency == 6'd0 && prev_lat == MAX_LAT - 1) seen_wrap = 1;
    prev_lat = int'(latency);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  bit sent[$];
  int dly     = 7;
  bit rnd_dec = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    ref_valid = 0; dec_valid = 0; clear = 0;
    repeat (n) tick();
  endtask

  // Paired ref/dec strobes; dec follows ref by dly events, with optional
  // periodic bit flips and random idle gaps.
  task automatic pairs(input int n, input int flip_period);
    bit r;
    int k;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) idle(1);
      r = 1'($urandom_range(1));
      k = sent.size() - dly;
      ref_valid = 1; ref_bit = r; dec_valid = 1;
      dec_bit = rnd_dec ? 1'($urandom_range(1)) : ((k >= 0) ? sent[k] : 1'b0);
      if (flip_period > 0 && (i + 1) % flip_period == 0) dec_bit = ~dec_bit;
      sent.push_back(r);
      tick();
    end
    ref_valid = 0; dec_valid = 0;
  endtask

  // Independent random strobes with uncorrelated decoded bits.
  task automatic random_traffic(input int n_dec);
    int cnt = 0;
    int cyc = 0;
    while (cnt < n_dec && cyc < 10 * n_dec) begin
      ref_valid = 1'($urandom_range(1));
      ref_bit   = 1'($urandom_range(1));
      dec_valid = 1'($urandom_range(1));
      dec_bit   = 1'($urandom_range(1));
      if (ref_valid) sent.push_back(ref_bit);
      if (dec_valid) cnt++;
      cyc++;
      tick();
    end
    ref_valid = 0; dec_valid = 0;
  endtask

  int p0;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_bit_count", 64'(bit_count), 64'd0);
    check("rst_sweep_fail", 64'(sweep_fail), 64'd0);
    rst = 1;
    idle(2);

    // 1: aligned stream, delay 7 -> latency 6 after 7 candidates of 32 bits
    dly = 7;
    pairs(1000, 0);
    check("t1_locked", 64'(locked), 64'd1);
    check("t1_latency", 64'(latency), 64'd6);
    check("t1_err_count", 64'(err_count), 64'd0);
    check("t1_bit_count", 64'(bit_count), 64'd776);

    // 2: every 16th decoded bit flipped over 512 bits
    pulse_cnt = 0;
    pairs(512, 16);
    idle(1);
    check("t2_err_count", 64'(err_count), 64'd32);
    check("t2_pulses", 64'(pulse_cnt), 64'd32);
    check("t2_locked", 64'(locked), 64'd1);
    check("t2_bit_count", 64'(bit_count), 64'd1288);

    // 3: alignment slips by 3 -> loss of lock, re-lock at latency 9
    dly = 10;
    seen_unlock = 0;
    pairs(2 * WIN, 0);
    check("t3_unlock_within_2win", 64'(seen_unlock), 64'd1);
    pairs(100, 0);
    check("t3_locked", 64'(locked), 64'd1);
    check("t3_latency", 64'(latency), 64'd9);

    // 4: uncorrelated decoded bits -> every candidate fails, latency wraps
    rnd_dec = 1;
    seen_wrap = 0;
    random_traffic(MAX_LAT * SRCH_LEN + 32 + WIN);
    rnd_dec = 0;
    check("t4_sweep_fail", 64'(sweep_fail), 64'd1);
    check("t4_locked", 64'(locked), 64'd0);
    check("t4_wrapped", 64'(seen_wrap), 64'd1);

    // 5: clear while locked with 5 errors, then reset mid-window
    dly = 7;
    clear = 1; tick(); clear = 0;
    pairs(240, 0);
    check("t5_relock", 64'(locked), 64'd1);
    pairs(100, 20);
    idle(1);
    check("t5_err_count", 64'(err_count), 64'd5);
    clear = 1; tick(); clear = 0;
    check("t5_clr_bit_count", 64'(bit_count), 64'd0);
    check("t5_clr_err_count", 64'(err_count), 64'd0);
    check("t5_clr_locked", 64'(locked), 64'd0);
    check("t5_clr_latency", 64'(latency), 64'd0);
    check("t5_clr_sweep_fail", 64'(sweep_fail), 64'd0);
    pairs(300, 0);
    check("t5_locked_mid_window", 64'(locked), 64'd1);
    rst = 0;
    #1;
    check("t5_rst_locked", 64'(locked), 64'd0);
    check("t5_rst_latency", 64'(latency), 64'd0);
    check("t5_rst_bit_count", 64'(bit_count), 64'd0);
    check("t5_rst_err_count", 64'(err_count), 64'd0);
    check("t5_rst_err_pulse", 64'(err_pulse), 64'd0);
    check("t5_rst_sweep_fail", 64'(sweep_fail), 64'd0);
    repeat (2) tick();
    rst = 1;
    idle(1);

    // 6: bit_count saturation freezes both counters
    pairs(240, 0);
    check("t6_locked", 64'(locked), 64'd1);
    check("t6_latency", 64'(latency), 64'd6);
    force dut.bit_count = 32'hFFFF_FFFE;
    m_bc = 32'hFFFF_FFFE;
    tick();
    release dut.bit_count;
    p0 = pulse_cnt;
    pairs(3, 2);
    idle(1);
    check("t6_bit_count_sat", 64'(bit_count), 64'hFFFF_FFFF);
    check("t6_err_frozen", 64'(err_count), 64'd0);
    check("t6_no_pulse", 64'(pulse_cnt), 64'(p0));
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
